// File: rtl/c_fifo_prefetch_if.sv
// c_fifo_prefetch_if: FIFO-controller, register-file and consumer signals of the prefetch stage
//   master: prefetch stage side (drives fifo_pop, out_valid, out_data, errors)
//   slave : environment side (drives fifo_empty, rf_data, out_ready)
interface c_fifo_prefetch_if #(
    parameter int width = 32
);
    logic             fifo_empty;
    logic             fifo_pop;
    logic [0:width-1] rf_data;
    logic             out_valid;
    logic             out_ready;
    logic [0:width-1] out_data;
    logic [0:1]       errors;
    modport master (
        input  fifo_empty, rf_data, out_ready,
        output fifo_pop, out_valid, out_data, errors
    );
    modport slave (
        output fifo_empty, rf_data, out_ready,
        input  fifo_pop, out_valid, out_data, errors
    );
endinterface

// File: rtl/c_fifo_prefetch.sv
// c_fifo_prefetch: read-side prefetch stage hiding the one-cycle register-file latency behind a small output buffer
//   i_clk    : clock, rising edge
//   i_reset  : asynchronous active-low reset
//   io_bus   : c_fifo_prefetch_if.master (fifo_empty/fifo_pop, rf_data, out_valid/out_ready/out_data, errors)
//   errors[0]: data returned with no free slot; errors[1]: pop issued while fifo_empty
//   Macro C_FIFO_PREFETCH_DECOUPLE_EN: 3-entry buffer, pop decision independent of out_ready
`ifndef RESET_TYPE_ASYNC
`define RESET_TYPE_ASYNC 1
`endif
module c_fifo_prefetch #(
    parameter int width      = 32,
    parameter int reset_type = `RESET_TYPE_ASYNC
) (
    input logic               i_clk,
    input logic               i_reset,
    c_fifo_prefetch_if.master io_bus
);
`ifdef C_FIFO_PREFETCH_DECOUPLE_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int              PW   = $clog2(N);
    localparam logic [PW-1:0]   LAST = PW'(N - 1);
    localparam logic [1:0]      FULL = 2'(N);
    if (reset_type != `RESET_TYPE_ASYNC) begin : g_reset_type_check
        $error("c_fifo_prefetch supports only the asynchronous reset style");
    end
    logic [0:width-1] r_mem [N];
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [1:0]       r_count;
    logic             r_inflight;
    logic             w_deq;
    logic             w_pop;
    logic             w_ovf;
    logic [1:0]       w_level;
    always_comb begin
        w_deq   = (r_count != 2'd0) & io_bus.out_ready;
`ifdef C_FIFO_PREFETCH_DECOUPLE_EN
        // the spare third slot absorbs the return of a pop issued the cycle ready falls
        w_level = r_count + {1'b0, r_inflight};
        w_pop   = ~io_bus.fifo_empty & (w_level < 2'd3);
`else
        // occupancy after this cycle's dequeue; a pop is safe only if a slot remains for its return
        w_level = r_count + {1'b0, r_inflight} - {1'b0, w_deq};
        w_pop   = ~io_bus.fifo_empty & (w_level < 2'd2);
`endif
        w_ovf   = r_inflight & (r_count == FULL) & ~w_deq;
    end
    assign io_bus.fifo_pop  = w_pop;
    assign io_bus.out_valid = r_count != 2'd0;
    assign io_bus.out_data  = r_mem[r_head];
    assign io_bus.errors    = {w_ovf, w_pop & io_bus.fifo_empty};
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < N; i++) r_mem[i] <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_pop;
            if (r_inflight) begin
                r_mem[r_tail] <= io_bus.rf_data;
                r_tail        <= (r_tail == LAST) ? '0 : r_tail + 1'b1;
            end
            if (w_deq) r_head <= (r_head == LAST) ? '0 : r_head + 1'b1;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_deq};
        end
    end
endmodule

// File: tb/tb_c_fifo_prefetch.sv
// tb_c_fifo_prefetch: randomized self-checking bench against a queue-based model of the prefetch stage
module tb_c_fifo_prefetch;
`ifdef C_FIFO_PREFETCH_DECOUPLE_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;
    c_fifo_prefetch_if #(.width(32)) bus();
    c_fifo_prefetch #(.width(32)) dut (
        .i_clk  (clk),
        .i_reset(reset_n),
        .io_bus (bus)
    );
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic [31:0] mq[$];
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_word = '0;
    logic [31:0] src_next = '0;
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          pop_cyc[$];

    task automatic model_reset();
        mq.delete();
        m_infl = 1'b0;
    endtask

    task automatic clear_logs();
        log_data.delete();
        log_cyc.delete();
        pop_cyc.delete();
    endtask

    task automatic drive_cycle(input bit empty, input bit ready);
        bit exp_valid, exp_pop, deq;
        int level;
        @(negedge clk);
        bus.fifo_empty = empty;
        bus.out_ready  = ready;
        bus.rf_data    = m_infl ? m_infl_word : $urandom;
        #1;
        exp_valid = mq.size() != 0;
        deq       = exp_valid && ready;
`ifdef C_FIFO_PREFETCH_DECOUPLE_EN
        level   = mq.size() + int'(m_infl);
        exp_pop = !empty && level < 3;
`else
        level   = mq.size() + int'(m_infl) - int'(deq);
        exp_pop = !empty && level < 2;
`endif
        n_checks++;
        if (bus.out_valid !== exp_valid) begin
            n_errors++;
            $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, bus.out_valid, exp_valid);
        end
        if (exp_valid) begin
            n_checks++;
            if (bus.out_data !== mq[0]) begin
                n_errors++;
                $display("FAIL out_data cyc=%0d got=%h exp=%h", cyc, bus.out_data, mq[0]);
            end
        end
        n_checks++;
        if (bus.fifo_pop !== exp_pop) begin
            n_errors++;
            $display("FAIL fifo_pop cyc=%0d got=%b exp=%b", cyc, bus.fifo_pop, exp_pop);
        end
        n_checks++;
        if (bus.errors !== 2'b00) begin
            n_errors++;
            $display("FAIL errors cyc=%0d got=%b exp=00", cyc, bus.errors);
        end
        if (deq) begin
            log_data.push_back(mq.pop_front());
            log_cyc.push_back(cyc);
        end
        if (m_infl) mq.push_back(m_infl_word);
        if (exp_pop) begin
            pop_cyc.push_back(cyc);
            m_infl_word = src_next;
            src_next++;
        end
        m_infl = exp_pop;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b1);
    endtask

    task automatic check_sequence(input string name, input logic [31:0] first, input int count);
        n_checks++;
        if (log_data.size() != count) begin
            n_errors++;
            $display("FAIL %s_count got=%0d exp=%0d", name, log_data.size(), count);
        end
        for (int i = 0; i < log_data.size() && i < count; i++) begin
            n_checks++;
            if (log_data[i] !== first + 32'(i)) begin
                n_errors++;
                $display("FAIL %s_order idx=%0d got=%h exp=%h", name, i, log_data[i], first + 32'(i));
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n        = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.out_ready  = 1'b0;
        bus.rf_data    = $urandom;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.fifo_pop !== 1'b0 || bus.errors !== 2'b00 || bus.out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_state got valid=%b pop=%b err=%b data=%h exp 0/0/00/0",
                     bus.out_valid, bus.fifo_pop, bus.errors, bus.out_data);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'($urandom_range(1)));
        n_checks++;
        if (bus.out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_idle_data got=%h exp=0", bus.out_data);
        end
    endtask

    task automatic test_single();
        src_next = 32'hA5A5A5A5;
        clear_logs();
        drive_cycle(1'b0, 1'b0);
        n_checks++;
        if (bus.fifo_pop !== 1'b1) begin
            n_errors++;
            $display("FAIL single_pop got=%b exp=1", bus.fifo_pop);
        end
        drive_cycle(1'b1, 1'b0);
        drive_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hA5A5A5A5) begin
            n_errors++;
            $display("FAIL single_out got valid=%b data=%h exp 1/a5a5a5a5", bus.out_valid, bus.out_data);
        end
        drive_cycle(1'b1, 1'b1);
        drive_cycle(1'b1, 1'b0);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_clear got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_stream();
        src_next = 0;
        clear_logs();
        for (int i = 0; i < 30; i++) drive_cycle(src_next >= 16, 1'b1);
        check_sequence("stream", 32'd0, 16);
        n_checks++;
        if (log_cyc.size() != 16 || pop_cyc.size() != 16 || log_cyc[0] != pop_cyc[0] + 2 || log_cyc[15] != log_cyc[0] + 15) begin
            n_errors++;
            $display("FAIL stream_timing got first_out=%0d last_out=%0d exp first_pop+2=%0d and consecutive",
                     log_cyc.size() > 0 ? log_cyc[0] : -1, log_cyc.size() > 15 ? log_cyc[15] : -1,
                     pop_cyc.size() > 0 ? pop_cyc[0] + 2 : -1);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        src_next = 100;
        clear_logs();
        held = '0;
        for (int i = 0; i < 30; i++) begin
            drive_cycle(src_next >= 112, !(i >= 4 && i < 9));
            if (i == 5) held = bus.out_data;
            if (i == 8) begin
                n_checks++;
                if (bus.fifo_pop !== 1'b0 || bus.out_data !== held || bus.out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL bp_hold got pop=%b data=%h valid=%b exp pop=0 data=%h valid=1",
                             bus.fifo_pop, bus.out_data, bus.out_valid, held);
                end
            end
        end
        check_sequence("backpressure", 32'd100, 12);
    endtask

    task automatic test_alternate();
        src_next = 200;
        clear_logs();
        for (int i = 0; i < 80; i++) drive_cycle(src_next >= 220, (i % 2) == 0);
        check_sequence("alternate", 32'd200, 20);
    endtask

    task automatic test_random();
        logic [31:0] first;
        first = $urandom;
        src_next = first;
        clear_logs();
        for (int i = 0; i < 300; i++) drive_cycle($urandom_range(2) == 0, 1'($urandom_range(1)));
        idle(N + 3);
        check_sequence("random", first, int'(src_next - first));
    endtask

    task automatic test_reset_mid();
        logic [31:0] first;
        src_next = 300;
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        bus.fifo_empty = 1'b1;
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid got valid=%b data=%h exp 0/0", bus.out_valid, bus.out_data);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        clear_logs();
        first = src_next;
        for (int i = 0; i < 20; i++) drive_cycle(src_next >= first + 4, 1'b1);
        check_sequence("reset_mid", first, 4);
    endtask

    initial begin
        bus.fifo_empty = 1'b1;
        bus.out_ready  = 1'b0;
        bus.rf_data    = '0;
        test_reset();
        test_single();
        idle(4);
        test_stream();
        idle(4);
        test_backpressure();
        idle(4);
        test_alternate();
        idle(4);
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
